// File: rtl/bnn_pkg.sv
// rtl/bnn_pkg.sv - shared constants, FSM state type and window index helper for the BNN window feeder
package bnn_pkg;

    localparam int K  = 7;
    localparam int KK = K * K;

    typedef enum logic [1:0] {
        LOAD_W,
        STREAM,
        ISSUE,
        EMIT
    } state_t;

    // Flat bit position of window row r (0 = oldest), column c (0 = leftmost).
    function automatic int idx(input int r, input int c);
        return r * K + c;
    endfunction

endpackage

// File: rtl/bnn_line_buffer.sv
// rtl/bnn_line_buffer.sv - DEPTH-deep 1-bit shift register used as one image line buffer
// Ports:
//   clk, rst : clock, synchronous active-high reset (clears contents)
//   en       : shift by one position
//   din      : bit entering the line
//   dout     : bit that entered DEPTH shifts ago (valid before the shift)
module bnn_line_buffer #(
    parameter int DEPTH = 28
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] sr;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= '0;
        end else if (en) begin
            sr <= {sr[DEPTH-2:0], din};
        end
    end

    assign dout = sr[DEPTH-1];

endmodule

// File: rtl/bnn_window_feeder.sv
// rtl/bnn_window_feeder.sv - builds 7x7 binary windows from a raster pixel stream and sequences the XNOR/popcount multiplier
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   pix_in/pix_valid/pix_ready  : binary pixel stream, raster order
//   w_row/w_valid/w_ready       : weight rows, first row loaded lands in w[6:0]
//   img, w                      : window and weights, bit r*7+c = row r, column c
//   step                        : multiplier row-advance enable, 7 cycles per window
//   acc_clr                     : multiplier accumulator clear
//   win_done                    : multiplier result valid this cycle
//   frame_done                  : last pixel of the frame accepted this cycle
module bnn_window_feeder #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int K     = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_in,
    input  logic             pix_valid,
    output logic             pix_ready,
    input  logic [K-1:0]     w_row,
    input  logic             w_valid,
    output logic             w_ready,
    output logic [K*K-1:0]   img,
    output logic [K*K-1:0]   w,
    output logic             step,
    output logic             acc_clr,
    output logic             win_done,
    output logic             frame_done
);

    import bnn_pkg::*;

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    state_t          state, state_nx;
    logic [CW-1:0]   col;
    logic [RW-1:0]   row;
    logic [2:0]      wcnt;
    logic [2:0]      icnt;
    logic [K-2:0]    lb_in;
    logic [K-2:0]    lb_out;
    logic [K*K-1:0]  img_nx;
    logic            at_bound, col_last, row_last, win_ok;
    logic            pix_acc, w_acc;

    assign at_bound = (row == '0) && (col == '0);
    assign col_last = (col == CW'(IMG_W - 1));
    assign row_last = (row == RW'(IMG_H - 1));
    // Only windows lying wholly inside the current frame and row are issued.
    assign win_ok   = (row >= RW'(K - 1)) && (col >= CW'(K - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD_W;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        pix_ready = 1'b0;
        w_ready   = 1'b0;
        step      = 1'b0;
        win_done  = 1'b0;
        acc_clr   = rst;
        case (state)
            LOAD_W: begin
                w_ready = 1'b1;
                acc_clr = 1'b1;
                if (w_valid && wcnt == 3'd6) begin
                    state_nx = STREAM;
                end
            end
            STREAM: begin
                // A weight row at the frame boundary has priority over the pixel.
                w_ready   = at_bound;
                pix_ready = !(at_bound && w_valid);
                if (at_bound && w_valid) begin
                    state_nx = LOAD_W;
                end else if (pix_valid && win_ok) begin
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                step = 1'b1;
                if (icnt == 3'd6) begin
                    state_nx = EMIT;
                end
            end
            EMIT: begin
                win_done = 1'b1;
                acc_clr  = 1'b1;
                state_nx = STREAM;
            end
            default: state_nx = LOAD_W;
        endcase
    end

    assign pix_acc    = pix_valid && pix_ready;
    assign w_acc      = w_valid && w_ready;
    assign frame_done = pix_acc && row_last && col_last;

    // Window shifts left; the new right column comes from the line-buffer taps,
    // oldest line in row 0, the incoming pixel in row 6.
    always_comb begin
        img_nx = img;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) begin
                img_nx[idx(r, c)] = img[idx(r, c + 1)];
            end
        end
        for (int r = 0; r < K - 1; r++) begin
            img_nx[idx(r, K - 1)] = lb_out[K - 2 - r];
        end
        img_nx[idx(K - 1, K - 1)] = pix_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col  <= '0;
            row  <= '0;
            wcnt <= '0;
            icnt <= '0;
            w    <= '0;
            img  <= '0;
        end else begin
            if (w_acc) begin
                w    <= {w_row, w[K*K-1:K]};
                wcnt <= (state == STREAM) ? 3'd1 : wcnt + 3'd1;
            end
            if (pix_acc) begin
                img <= img_nx;
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
            icnt <= (state == ISSUE) ? icnt + 3'd1 : 3'd0;
        end
    end

    assign lb_in = {lb_out[K-3:0], pix_in};

    for (genvar i = 0; i < K - 1; i++) begin : g_lb
        bnn_line_buffer #(
            .DEPTH (IMG_W)
        ) u_lb (
            .clk  (clk),
            .rst  (rst),
            .en   (pix_acc),
            .din  (lb_in[i]),
            .dout (lb_out[i])
        );
    end

endmodule

// File: tb/tb_bnn_window_feeder.sv
// tb/tb_bnn_window_feeder.sv - directed self-checking bench for bnn_window_feeder on an 8x8 image
module tb_bnn_window_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_in, pix_valid, pix_ready;
    logic [6:0]  w_row;
    logic        w_valid, w_ready;
    logic [48:0] img, w;
    logic        step, acc_clr, win_done, frame_done;

    int total = 0;
    int bad   = 0;

    localparam logic [48:0] W1   = 49'h1_0101_0101_0101;
    localparam logic [48:0] W2   = {7'h01, 7'h00, 7'h7F, 7'h2A, 7'h55, 7'h00, 7'h7F};
    localparam logic [48:0] ONES = 49'h1_FFFF_FFFF_FFFF;

    bnn_window_feeder #(
        .IMG_W (8),
        .IMG_H (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .w_row      (w_row),
        .w_valid    (w_valid),
        .w_ready    (w_ready),
        .img        (img),
        .w          (w),
        .step       (step),
        .acc_clr    (acc_clr),
        .win_done   (win_done),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic pat(input bit cb, input int i);
        int v;
        v = ((i % 8) ^ (i / 8)) & 1;
        return cb ? v[0] : 1'b1;
    endfunction

    // Window k of an 8x8 frame ends at row 6+k/2, column 6+k%2.
    function automatic logic [48:0] exp_win(input bit cb, input int k);
        logic [48:0] e;
        int rr, cc;
        rr = 6 + k / 2;
        cc = 6 + k % 2;
        for (int r = 0; r < 7; r++) begin
            for (int c = 0; c < 7; c++) begin
                e[r*7+c] = cb ? (((r + c + rr + cc) % 2) == 1) : 1'b1;
            end
        end
        return e;
    endfunction

    task automatic run_frame(input bit cb, input logic [48:0] wexp);
        int idx, wins, srun, fdone;
        bit prev_win;
        idx = 0; wins = 0; srun = 0; fdone = 0; prev_win = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            pix_valid = (idx < 64);
            pix_in    = pat(cb, idx);
            #1;
            if (step) begin
                chk("issue_noready", pix_ready, 0);
                if (srun == 0) begin
                    chk("issue_idx", idx, (6 + wins / 2) * 8 + 6 + wins % 2 + 1);
                end
                chk("issue_img", img, exp_win(cb, wins));
                chk("issue_w", w, wexp);
                srun++;
            end
            if (win_done) begin
                chk("step_len", srun, 7);
                chk("emit_clr", acc_clr, 1);
                chk("emit_noready", pix_ready, 0);
                srun = 0;
                wins++;
            end else if (!step) begin
                chk("stream_clr", acc_clr, 0);
            end
            if (prev_win && idx < 64) chk("resume_ready", pix_ready, 1);
            prev_win = win_done;
            if (frame_done) begin
                fdone++;
                chk("fdone_idx", idx, 63);
            end
            if (pix_valid && pix_ready) idx++;
            if (win_done && wins == 4 && idx == 64) break;
        end
        chk("frame_wins", wins, 4);
        chk("frame_pix", idx, 64);
        chk("frame_fdone", fdone, 1);
        pix_valid = 1'b0;
    endtask

    initial begin
        int s;
        rst = 1'b1; pix_in = 1'b0; pix_valid = 1'b0; w_row = '0; w_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_pix_ready", pix_ready, 0);
        chk("rst_w_ready", w_ready, 1);
        chk("rst_acc_clr", acc_clr, 1);
        chk("rst_step", step, 0);
        chk("rst_win_done", win_done, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_img", img, 0);
        chk("rst_w", w, 0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            w_valid = 1'b1;
            w_row   = 7'(1 << i);
            #1;
            chk("load_w_ready", w_ready, 1);
            chk("load_pix_ready", pix_ready, 0);
        end
        @(negedge clk);
        w_valid = 1'b0;
        #1;
        chk("load_w", w, W1);
        chk("load_stream_ready", pix_ready, 1);
        chk("load_stream_clr", acc_clr, 0);

        run_frame(1'b0, W1);
        run_frame(1'b1, W1);

        @(negedge clk);
        pix_valid = 1'b1; pix_in = 1'b1;
        w_valid = 1'b1; w_row = W2[6:0];
        #1;
        chk("bound_pix_ready", pix_ready, 0);
        chk("bound_w_ready", w_ready, 1);
        for (int i = 1; i < 7; i++) begin
            @(negedge clk);
            w_row = W2[i*7 +: 7];
            #1;
            chk("reload_pix_stall", pix_ready, 0);
            chk("reload_w_ready", w_ready, 1);
            chk("reload_clr", acc_clr, 1);
        end
        @(negedge clk);
        w_valid = 1'b0;
        #1;
        chk("reload_w", w, W2);
        chk("reload_pix_ready", pix_ready, 1);

        s = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            #1;
            if (step) s++;
            if (s == 3) break;
        end
        chk("third_issue", s, 3);
        rst = 1'b1;
        #1;
        chk("rst_issue_clr", acc_clr, 1);
        @(negedge clk);
        #1;
        chk("mid_rst_step", step, 0);
        chk("mid_rst_win_done", win_done, 0);
        chk("mid_rst_clr", acc_clr, 1);
        chk("mid_rst_w", w, 0);
        chk("mid_rst_img", img, 0);
        chk("mid_rst_pix_ready", pix_ready, 0);
        chk("mid_rst_w_ready", w_ready, 1);
        rst = 1'b0;
        pix_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bnn_window_feeder.md
Name: bnn_window_feeder

Overview:
Upstream feeder for the binary XNOR/popcount multiplier. It accepts a raster-order binary pixel stream and a 7-row weight load, and builds 7x7 binary windows using line buffers. For each complete window it holds img/w stable and issues 7 row-step pulses so the multiplier accumulates one row per cycle. It then flags the accumulated result and clears the multiplier accumulator.

Parameters:
IMG_W, 28, pixels per image row (>= 7)
IMG_H, 28, rows per frame (>= 7)
K, 7, window side; fixed at 7 (49-bit vectors), not to be overridden

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
pix_in  in  1  binary pixel (1 = +1, 0 = -1)
pix_valid  in  1  pixel present
pix_ready  out  1  pixel accepted when pix_valid && pix_ready
w_row  in  7  one weight row; bit c = column c
w_valid  in  1  weight row present
w_ready  out  1  weight row accepted when w_valid && w_ready
img  out  49  window; img[r*7+c] = pixel at window row r (0 = oldest), column c (0 = leftmost)
w  out  49  weights, same layout as img
step  out  1  multiplier row-advance/accumulate enable
acc_clr  out  1  multiplier accumulator clear (drives its rst)
win_done  out  1  1-cycle pulse: multiplier result valid this cycle
frame_done  out  1  1-cycle pulse: last pixel of frame accepted

Behaviour:
- Reset: state LOAD_W, col = row = 0, weight count = 0, w = 0, img = 0, line buffers = 0. Outputs step, win_done and frame_done are 0. pix_ready = 0, w_ready = 1, acc_clr = 1 (asserted during reset cycle too).
- FSM states: LOAD_W, STREAM, ISSUE, EMIT.
- LOAD_W:
  - w_ready = 1. Each accepted row shifts: w <= {w_row, w[48:7]}, so the first row loaded ends in w[6:0].
  - Go to STREAM on the 7th accepted row, i.e. when the weight count reaches 7.
- STREAM:
  - pix_ready = 1. w_ready = 1 only when row == 0 && col == 0 (frame boundary).
  - An accepted w_row at the frame boundary returns the FSM to LOAD_W with count = 1, after the same shift.
  - If pix_valid and w_valid arrive together at the boundary, the weight wins and pix_ready is 0 that cycle.
- Accepted pixel:
  - 6 chained IMG_W-deep line buffers each shift by one. Window columns shift left (column 0 dropped).
  - New column 6: row 6 = pix_in, row 5 = line buffer 0 output, ..., row 0 = line buffer 5 output.
  - col increments and wraps at IMG_W-1 with row++. row wraps at IMG_H-1 to 0, and frame_done pulses in the acceptance cycle.
  - If the accepted pixel had row >= 6 && col >= 6 (pre-increment values), go to ISSUE next cycle with the issue counter = 0. Otherwise stay in STREAM.
- ISSUE:
  - pix_ready = 0, w_ready = 0, step = 1 for exactly 7 consecutive cycles (issue counter 0..6).
  - img and w are held stable throughout. Then go to EMIT.
- EMIT (1 cycle):
  - win_done = 1 (the multiplier's registered sum reflects all 7 steps).
  - acc_clr = 1. step = 0, pix_ready = 0. Next state is STREAM.
- acc_clr is 1 in reset, in LOAD_W and in EMIT, and 0 otherwise.
- Throughput: one window per 9 cycles minimum (accept + 7 ISSUE + EMIT). Windows per frame = (IMG_H-6)*(IMG_W-6).
- Windows spanning a row wrap (col < 6) are never issued. Stale line-buffer data across frames is never issued because row >= 6 is required.
- rst mid-ISSUE/EMIT: everything is cleared, including weights. The partial window is discarded and acc_clr clears the multiplier.
- pix_valid with no pix_ready: the pixel is held by the source, not dropped.

Decomposition:
- Shared package bnn_pkg holds:
  - K = 7, KK = 49.
  - State enum {LOAD_W, STREAM, ISSUE, EMIT}.
  - Index function idx(r, c) = r*7 + c.
- One sub-module, bnn_line_buffer: an IMG_W-deep 1-bit shift register with shift enable. It is instantiated 6 times.

Test Plan:
- Weight load: rows 7'h01, 7'h02, ..., 7'h40 → after the 7th, w = those rows packed row 0 to row 6 with w[6:0] = 7'h01. FSM is in STREAM and pix_ready rises next cycle. Then pix_valid held high at the frame boundary with w_valid = 0 → pixel accepted.
- IMG_W = IMG_H = 8, all-ones frame with pix_valid held high:
  - First issue follows acceptance of pixel index 54 (row 6, col 6). img = 49'h1_FFFF_FFFF_FFFF.
  - step high for exactly 7 cycles, then a 1-cycle win_done with acc_clr.
  - 4 win_done pulses total and frame_done on pixel 63.
- 8x8 checkerboard pix = (x ^ y) & 1 → window at (row 6, col 6): img[r*7+c] = (r + c) & 1. Window at (row 6, col 7): img[r*7+c] = (r + c + 1) & 1.
- Backpressure: pix_valid held high through ISSUE/EMIT → pix_ready = 0 for those 8 cycles. The pixel is accepted on the first STREAM cycle, and no pixel is lost or duplicated.
- Frame-boundary reload: at row = col = 0, present w_valid and pix_valid together → weight accepted, FSM enters LOAD_W, pixel stalls until 6 more rows are loaded.
- Reset on the 3rd ISSUE cycle → next cycle step = 0, win_done = 0, acc_clr = 1, state LOAD_W, w = 0, pix_ready = 0.
